// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - memory map constants, IO offsets and FSM state encoding
package mem_bus_responder_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT   = 16'hCFFD;
    localparam logic [15:0] INSTRUCTION_MEM   = 16'h0000;
    localparam logic [15:0] INTERRUPT_CONTROL = 16'h5FFF;
    localparam logic [15:0] DATA_STACK        = 16'h6FFE;

    localparam logic [1:0] IO_IN      = 2'd0;
    localparam logic [1:0] IO_OUT     = 2'd1;
    localparam logic [1:0] IO_STATUS  = 2'd2;
    localparam logic [1:0] IO_SCRATCH = 2'd3;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - CPU memory port handshake bundle
interface mem_bus_responder_if #(
    parameter int WIDTH = 16
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ack;
    logic             err;

    modport master (output req, we, addr, wdata, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_bus_responder_io_regfile.sv
// rtl/mem_bus_responder_io_regfile.sv - IO window: io_in synchroniser, OUT/SCRATCH registers, read mux
module mem_bus_responder_io_regfile
    import mem_bus_responder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_in,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic [WIDTH-1:0] io_out
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] scratch_q;

    // Anything past the four defined registers is unmapped.
    assign err    = |offset[WIDTH-1:2];
    assign io_out = out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            out_q     <= '0;
            scratch_q <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
            if (wr_en && !err) begin
                case (offset[1:0])
                    IO_OUT:     out_q     <= wdata;
                    IO_SCRATCH: scratch_q <= wdata;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (!err) begin
            case (offset[1:0])
                IO_IN:      rdata = sync2;
                IO_OUT:     rdata = out_q;
                IO_STATUS:  rdata = {{(WIDTH-1){1'b0}}, |sync2};
                IO_SCRATCH: rdata = scratch_q;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - wait-stated memory responder: FSM, address latch, RAM and region decode
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               MEM_AW      = 10,
    parameter int               WAIT_STATES = 1,
    parameter logic [WIDTH-1:0] IO_BASE     = WIDTH'(IO_BASE_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_responder_if.slave   bus,
    input  logic [WIDTH-1:0]     io_in,
    output logic [WIDTH-1:0]     io_out
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;
    logic             lat_we;
    logic [WIDTH-1:0] rdata_q;
    logic             ack_q;
    logic             err_q;

    logic [WIDTH-1:0] ram [2**MEM_AW];
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] io_rdata;
    logic [WIDTH-1:0] io_offset;
    logic             io_err;
    logic             is_io;
    logic             commit;

    assign commit    = (state == ST_BUSY) && (cnt == '0);
    assign is_io     = (lat_addr >= IO_BASE);
    assign io_offset = lat_addr - IO_BASE;
    // Upper address bits are not decoded below IO_BASE, so the RAM aliases.
    assign ram_rdata = ram[lat_addr[MEM_AW-1:0]];

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;

    always_ff @(posedge clk) begin
        if (commit && lat_we && !is_io) begin
            ram[lat_addr[MEM_AW-1:0]] <= lat_wdata;
        end
    end

    mem_bus_responder_io_regfile #(
        .WIDTH(WIDTH)
    ) u_io (
        .clk    (clk),
        .reset  (reset),
        .io_in  (io_in),
        .wr_en  (commit && lat_we && is_io),
        .offset (io_offset),
        .wdata  (lat_wdata),
        .rdata  (io_rdata),
        .err    (io_err),
        .io_out (io_out)
    );

    // ack/err are set on the commit edge so they are high for exactly the RESP cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.wdata;
                        lat_we    <= bus.we;
                        cnt       <= CNT_W'(WAIT_STATES);
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!lat_we) begin
                            rdata_q <= is_io ? io_rdata : ram_rdata;
                        end
                        err_q <= is_io && io_err;
                        ack_q <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_HOLD;
                ST_HOLD: begin
                    if (!bus.req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - self-checking bench with a memory-map reference model
module tb_mem_bus_responder;

    localparam int          WIDTH   = 16;
    localparam int          MEM_AW  = 10;
    localparam int          WS      = 1;
    localparam logic [15:0] IO_BASE = 16'hCFFD;
    localparam int          LAT     = WS + 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] io_in = '0;
    logic [15:0] io_out;

    mem_bus_responder_if #(.WIDTH(WIDTH)) bus ();

    mem_bus_responder #(
        .WIDTH(WIDTH), .MEM_AW(MEM_AW), .WAIT_STATES(WS), .IO_BASE(IO_BASE)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .io_in(io_in), .io_out(io_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [15:0] ram_m [int];
    logic [15:0] wr_q [$];
    logic [15:0] out_m     = '0;
    logic [15:0] scratch_m = '0;
    logic [15:0] exp_rdata = '0;

    // Reference: word RAM of 1024 entries below IO_BASE, four IO registers above it.
    function automatic void model(input logic w, input logic [15:0] a, input logic [15:0] wd,
                                  output logic [15:0] rd, output logic er);
        int off;
        rd = '0;
        er = 1'b0;
        if (a < IO_BASE) begin
            if (w) ram_m[int'(a) % 1024] = wd;
            else   rd = ram_m[int'(a) % 1024];
        end else begin
            off = int'(a) - int'(IO_BASE);
            case (off)
                0: rd = io_in;
                1: begin if (w) out_m = wd; rd = out_m; end
                2: rd = (io_in != 0) ? 16'd1 : 16'd0;
                3: begin if (w) scratch_m = wd; rd = scratch_m; end
                default: begin rd = '0; er = 1'b1; end
            endcase
        end
        if (!w) exp_rdata = rd;
    endfunction

    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd, output logic er,
                          output logic ack_next);
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = wd;
        lat = 0; rd = 'x; er = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.ack) begin
                lat = i; rd = bus.rdata; er = bus.err;
                break;
            end
        end
        bus.req = 1'b0;
        bus.we = 1'($urandom); bus.addr = 16'($urandom); bus.wdata = 16'($urandom);
        @(posedge clk); #1;
        ack_next = bus.ack;
        @(posedge clk);
    endtask

    task automatic test_reset();
        int acks;
        int lat;
        logic [15:0] rd;
        logic er, an;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0)   $display("FAIL reset_ack got %b want 0", bus.ack); else passed++;
        checks++; if (bus.err !== 1'b0)   $display("FAIL reset_err got %b want 0", bus.err); else passed++;
        checks++; if (bus.rdata !== 16'h0) $display("FAIL reset_rdata got %h want 0000", bus.rdata); else passed++;
        checks++; if (io_out !== 16'h0)   $display("FAIL reset_io_out got %h want 0000", io_out); else passed++;

        bus.req = 1'b1; bus.we = 1'b1; bus.addr = IO_BASE + 16'd1; bus.wdata = 16'hFFFF;
        @(posedge clk); #1;
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.ack) acks++;
        end
        @(negedge clk); bus.req = 1'b0; reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack) acks++;
        end
        checks++; if (acks !== 0)          $display("FAIL midreset_ack got %0d pulses want 0", acks); else passed++;
        checks++; if (io_out !== 16'h0)    $display("FAIL midreset_io_out got %h want 0000", io_out); else passed++;
        checks++; if (bus.rdata !== 16'h0) $display("FAIL midreset_rdata got %h want 0000", bus.rdata); else passed++;

        access(1'b0, IO_BASE + 16'd3, 16'h0, lat, rd, er, an);
        checks++; if (lat !== LAT)   $display("FAIL post_reset_latency got %0d want %0d", lat, LAT); else passed++;
        checks++; if (rd !== 16'h0)  $display("FAIL post_reset_scratch got %h want 0000", rd); else passed++;
        exp_rdata = 16'h0;
    endtask

    task automatic test_ram_basic();
        int lat;
        logic [15:0] rd, exp;
        logic er, an, exp_er;
        model(1'b1, 16'h0010, 16'hBEEF, exp, exp_er); wr_q.push_back(16'h0010);
        access(1'b1, 16'h0010, 16'hBEEF, lat, rd, er, an);
        checks++; if (lat !== LAT) $display("FAIL ram_wr_latency got %0d want %0d", lat, LAT); else passed++;
        checks++; if (an !== 1'b0) $display("FAIL ram_wr_ack_width got %b want 0", an); else passed++;
        checks++; if (rd !== 16'h0) $display("FAIL ram_wr_rdata_kept got %h want 0000", rd); else passed++;
        model(1'b0, 16'h0010, 16'h0, exp, exp_er);
        access(1'b0, 16'h0010, 16'h0, lat, rd, er, an);
        checks++; if (lat !== LAT)     $display("FAIL ram_rd_latency got %0d want %0d", lat, LAT); else passed++;
        checks++; if (rd !== 16'hBEEF) $display("FAIL ram_rd_data got %h want beef", rd); else passed++;
        checks++; if (er !== 1'b0)     $display("FAIL ram_rd_err got %b want 0", er); else passed++;
    endtask

    task automatic test_alias();
        int lat;
        logic [15:0] rd, exp;
        logic er, an, exp_er;
        model(1'b1, 16'h0400, 16'h1234, exp, exp_er); wr_q.push_back(16'h0400);
        access(1'b1, 16'h0400, 16'h1234, lat, rd, er, an);
        model(1'b0, 16'h0000, 16'h0, exp, exp_er);
        access(1'b0, 16'h0000, 16'h0, lat, rd, er, an);
        checks++; if (rd !== 16'h1234) $display("FAIL alias_rd got %h want 1234", rd); else passed++;
    endtask

    task automatic test_io();
        int lat;
        logic [15:0] rd, exp;
        logic er, an, exp_er;
        model(1'b1, 16'hCFFE, 16'h00A5, exp, exp_er);
        access(1'b1, 16'hCFFE, 16'h00A5, lat, rd, er, an);
        checks++; if (io_out !== 16'h00A5) $display("FAIL io_out_wr got %h want 00a5", io_out); else passed++;
        checks++; if (er !== 1'b0)         $display("FAIL io_out_err got %b want 0", er); else passed++;
        @(negedge clk); io_in = 16'h0003;
        repeat (3) @(posedge clk);
        model(1'b0, 16'hCFFD, 16'h0, exp, exp_er);
        access(1'b0, 16'hCFFD, 16'h0, lat, rd, er, an);
        checks++; if (rd !== 16'h0003) $display("FAIL io_in_rd got %h want 0003", rd); else passed++;
        model(1'b0, 16'hCFFF, 16'h0, exp, exp_er);
        access(1'b0, 16'hCFFF, 16'h0, lat, rd, er, an);
        checks++; if (rd !== 16'h0001) $display("FAIL io_status_rd got %h want 0001", rd); else passed++;
    endtask

    task automatic test_unmapped();
        int lat;
        logic [15:0] rd, exp;
        logic er, an, exp_er;
        model(1'b0, 16'hD001, 16'h0, exp, exp_er);
        access(1'b0, 16'hD001, 16'h0, lat, rd, er, an);
        checks++; if (rd !== 16'h0) $display("FAIL unmapped_rd got %h want 0000", rd); else passed++;
        checks++; if (er !== 1'b1)  $display("FAIL unmapped_rd_err got %b want 1", er); else passed++;
        model(1'b1, 16'hD001, 16'h5A5A, exp, exp_er);
        access(1'b1, 16'hD001, 16'h5A5A, lat, rd, er, an);
        checks++; if (er !== 1'b1)     $display("FAIL unmapped_wr_err got %b want 1", er); else passed++;
        checks++; if (io_out !== out_m) $display("FAIL unmapped_wr_io_out got %h want %h", io_out, out_m); else passed++;
        model(1'b0, IO_BASE + 16'd3, 16'h0, exp, exp_er);
        access(1'b0, IO_BASE + 16'd3, 16'h0, lat, rd, er, an);
        checks++; if (rd !== exp) $display("FAIL unmapped_wr_scratch got %h want %h", rd, exp); else passed++;
    endtask

    task automatic test_handshake();
        int acks, lat;
        logic [15:0] rd, exp, wd;
        logic er, an, exp_er;
        model(1'b0, 16'h0010, 16'h0, exp, exp_er);
        @(negedge clk); bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.ack) acks++;
        end
        checks++; if (acks !== 1) $display("FAIL held_req_acks got %0d want 1", acks); else passed++;
        @(negedge clk); bus.req = 1'b0;
        @(negedge clk);
        model(1'b0, 16'h0400, 16'h0, exp, exp_er);
        access(1'b0, 16'h0400, 16'h0, lat, rd, er, an);
        checks++; if (lat !== LAT)  $display("FAIL rearm_latency got %0d want %0d", lat, LAT); else passed++;
        checks++; if (rd !== exp)   $display("FAIL rearm_rd got %h want %h", rd, exp); else passed++;

        wd = 16'($urandom);
        model(1'b1, IO_BASE + 16'd3, wd, exp, exp_er);
        @(negedge clk); bus.req = 1'b1; bus.we = 1'b1; bus.addr = IO_BASE + 16'd3; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.addr = IO_BASE + 16'd1; bus.wdata = ~wd;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.ack) acks++;
        end
        checks++; if (acks !== 1)      $display("FAIL busy_drop_acks got %0d want 1", acks); else passed++;
        checks++; if (io_out !== out_m) $display("FAIL latched_addr_io_out got %h want %h", io_out, out_m); else passed++;
        model(1'b0, IO_BASE + 16'd3, 16'h0, exp, exp_er);
        access(1'b0, IO_BASE + 16'd3, 16'h0, lat, rd, er, an);
        checks++; if (rd !== wd) $display("FAIL busy_drop_commit got %h want %h", rd, wd); else passed++;
    endtask

    task automatic test_random();
        int lat, op;
        logic [15:0] a, wd, rd, exp, prev;
        logic w, er, an, exp_er;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 4);
            if (op == 1 && wr_q.size() == 0) op = 0;
            if (op == 4) begin
                @(negedge clk); io_in = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
                repeat (3) @(posedge clk);
                op = 3;
            end
            wd = 16'($urandom);
            case (op)
                0: begin w = 1'b1; a = 16'($urandom_range(0, int'(IO_BASE) - 1)); wr_q.push_back(a); end
                1: begin
                    w = 1'b0;
                    a = wr_q[$urandom_range(0, wr_q.size() - 1)];
                    a = {6'($urandom_range(0, 50)), a[9:0]};
                end
                default: begin
                    w = (op == 2);
                    if ($urandom_range(0, 3) == 0) a = IO_BASE + 16'($urandom_range(4, 16'hFFFF - int'(IO_BASE)));
                    else                           a = IO_BASE + 16'($urandom_range(0, 3));
                end
            endcase
            prev = exp_rdata;
            model(w, a, wd, exp, exp_er);
            access(w, a, wd, lat, rd, er, an);
            checks++;
            if (lat !== LAT || an !== 1'b0)
                $display("FAIL rnd_timing n=%0d got lat %0d ack_after %b want lat %0d ack_after 0", n, lat, an, LAT);
            else passed++;
            checks++; if (er !== exp_er) $display("FAIL rnd_err n=%0d addr %h got %b want %b", n, a, er, exp_er); else passed++;
            checks++;
            if (!w && rd !== exp)      $display("FAIL rnd_rd n=%0d addr %h got %h want %h", n, a, rd, exp);
            else if (w && rd !== prev) $display("FAIL rnd_wr_rdata n=%0d addr %h got %h want %h", n, a, rd, prev);
            else passed++;
            checks++; if (io_out !== out_m) $display("FAIL rnd_io_out n=%0d got %h want %h", n, io_out, out_m); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_ram_basic();
        test_alias();
        test_io();
        test_unmapped();
        test_handshake();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
